// File: rtl/imm_narrow.sv
// Purpose : narrow a 16-bit signed value into the 12/10-bit instruction immediate field, flag and count misfits.
// Latency : 2 cycles (stage 1 registers word + fit, stage 2 registers the packed field); one word per cycle.
// Backpr. : both stages advance when empty or draining; with out_ready=0 two words are held, then in_ready=0.
//
// Ports:
//   CLK, reset          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_data = signed value, imSlct = field select (0: 12-bit, 1: 10-bit)
//   out_valid/out_ready output handshake; out_imm = packed field, out_ovf = misfit, out_slct = carried select
//   cnt_clr, ovf_count  synchronous clear / saturating count of delivered overflowing words
//
// Optional feature: define IMM_NARROW_SATURATE_EN to clamp overflowing words to the field's
// signed extreme instead of truncating them. Without it no clamp logic exists.

module imm_narrow #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             imSlct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_imm,
    output logic             out_ovf,
    output logic             out_slct,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_count
);

    // Stage 1 state. Only the low 12 bits are kept: the upper bits matter
    // solely for the fit decision, which is made on the way in.
    logic        s1_valid;
    logic [11:0] s1_low;
    logic        s1_slct;
    logic        s1_fit;
`ifdef IMM_NARROW_SATURATE_EN
    logic        s1_neg;
`endif

    logic        s2_free;
    logic        s1_moves;
    logic        in_xfer;
    logic        out_xfer;
    logic        fit_in;
    logic [11:0] packed_imm;

    assign out_xfer = out_valid && out_ready;
    // Stage 2 can take a word when empty or when its word leaves on this edge.
    assign s2_free  = !out_valid || out_ready;
    assign s1_moves = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_moves;
    assign in_xfer  = in_valid && in_ready;

    // A value fits when every bit above the field's sign bit equals that sign bit.
    assign fit_in = imSlct ? ((&in_data[15:9])  || !(|in_data[15:9]))
                           : ((&in_data[15:11]) || !(|in_data[15:11]));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_low   <= 12'h000;
            s1_slct  <= 1'b0;
            s1_fit   <= 1'b1;
`ifdef IMM_NARROW_SATURATE_EN
            s1_neg   <= 1'b0;
`endif
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_low   <= in_data[11:0];
            s1_slct  <= imSlct;
            s1_fit   <= fit_in;
`ifdef IMM_NARROW_SATURATE_EN
            s1_neg   <= in_data[15];
`endif
        end else if (s1_moves) begin
            s1_valid <= 1'b0;
        end
    end

    // Field packing: the 10-bit field leaves bits [11:10] zero.
    always_comb begin
        packed_imm = s1_slct ? {2'b00, s1_low[9:0]} : s1_low;
`ifdef IMM_NARROW_SATURATE_EN
        if (!s1_fit) begin
            if (s1_neg) packed_imm = s1_slct ? 12'h200 : 12'h800;
            else        packed_imm = s1_slct ? 12'h1FF : 12'h7FF;
        end
`endif
    end

    // Stage 2 = output registers; frozen while the downstream stalls.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_imm   <= 12'h000;
            out_ovf   <= 1'b0;
            out_slct  <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_imm  <= packed_imm;
                out_ovf  <= !s1_fit;
                out_slct <= s1_slct;
            end
        end
    end

    // Counts overflowing words as they are handed downstream; clear has priority.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ovf_count <= '0;
        end else if (cnt_clr) begin
            ovf_count <= '0;
        end else if (out_xfer && out_ovf && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_narrow.sv
module tb_imm_narrow;

`ifdef IMM_NARROW_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        imSlct;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_imm;
    logic        out_ovf;
    logic        out_slct;
    logic        cnt_clr;
    logic [7:0]  ovf_count;

    int errors = 0;
    int checks = 0;

    imm_narrow #(.CNT_W(8)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .imSlct    (imSlct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_ovf   (out_ovf),
        .out_slct  (out_slct),
        .cnt_clr   (cnt_clr),
        .ovf_count (ovf_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one word with out_ready=1 and checks it arrives two edges later.
    task automatic send_one(input string tag, input logic [15:0] d, input logic s,
                            input logic [11:0] ei, input logic eo);
        in_valid = 1'b1;
        in_data  = d;
        imSlct   = s;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check({tag, "_lat1_vld"}, 32'(out_valid), 32'd0);
        @(posedge CLK); #1;
        check({tag, "_vld"},  32'(out_valid), 32'd1);
        check({tag, "_imm"},  32'(out_imm),   32'(ei));
        check({tag, "_ovf"},  32'(out_ovf),   32'(eo));
        check({tag, "_slct"}, 32'(out_slct),  32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        int          rcv;
        int          xf;
        int          first_c;
        int          last_c;
        int          cnt100;
        logic        stale;
        logic [11:0] got_w[$];

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        imSlct    = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm",   32'(out_imm),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_out_slct",  32'(out_slct),  32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        reset = 1'b1;
        @(posedge CLK); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: fits, misfits and field edges for both selects
        send_one("v_fff5",   16'hFFF5, 1'b0, 12'hFF5, 1'b0);
        send_one("v_0200s1", 16'h0200, 1'b1, SAT ? 12'h1FF : 12'h200, 1'b1);
        send_one("v_8000",   16'h8000, 1'b0, SAT ? 12'h800 : 12'h000, 1'b1);
        send_one("v_01ffs1", 16'h01FF, 1'b1, 12'h1FF, 1'b0);
        send_one("v_fe00s1", 16'hFE00, 1'b1, 12'h200, 1'b0);
        send_one("v_07ff",   16'h07FF, 1'b0, 12'h7FF, 1'b0);
        send_one("v_0800",   16'h0800, 1'b0, SAT ? 12'h7FF : 12'h800, 1'b1);
        send_one("v_fc00s1", 16'hFC00, 1'b1, SAT ? 12'h200 : 12'h000, 1'b1);
        @(posedge CLK); #1;
        check("vec_ovf_count", 32'(ovf_count), 32'd4);
        check("vec_drained",   32'(out_valid), 32'd0);

        // Backpressure: 8 words, out_ready low for the first 5 cycles
        acc = 0; rcv = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            out_ready = (c >= 5);
            in_valid  = (acc < 8);
            in_data   = 16'(acc + 1);
            imSlct    = 1'b0;
            #1;
            if (c == 4) begin
                check("bp_accepts",  32'(acc),       32'd2);
                check("bp_in_ready", 32'(in_ready),  32'd0);
                check("bp_hold_vld", 32'(out_valid), 32'd1);
                check("bp_hold_imm", 32'(out_imm),   32'd1);
            end
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                got_w.push_back(out_imm);
                if (first_c < 0) first_c = c;
                last_c = c;
                rcv++;
            end
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(rcv), 32'd8);
        check("bp_span",  32'(last_c - first_c), 32'd7);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_word%0d", i),
                  32'((i < got_w.size()) ? got_w[i] : 12'hFFF), 32'(i + 1));
        end

        // Saturation: 300 overflowing transfers into an 8-bit counter
        cnt_clr = 1'b1;
        @(posedge CLK); #1;
        cnt_clr = 1'b0;
        check("sat_cleared", 32'(ovf_count), 32'd0);
        acc = 0; xf = 0; cnt100 = 0;
        for (int c = 0; c < 400 && xf < 300; c++) begin
            in_valid = (acc < 300);
            in_data  = 16'h8000;
            imSlct   = 1'b0;
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready && out_ovf) xf++;
            @(posedge CLK); #1;
            if (xf == 100) cnt100 = 32'(ovf_count);
        end
        in_valid = 1'b0;
        check("sat_xfers",     32'(xf),        32'd300);
        check("sat_mid_count", 32'(cnt100),    32'd100);
        check("sat_count",     32'(ovf_count), 32'd255);

        // Clear on the same edge as an increment
        in_valid = 1'b1;
        in_data  = 16'h8000;
        imSlct   = 1'b0;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        check("clr_pre_ovf", 32'(out_valid && out_ovf), 32'd1);
        cnt_clr = 1'b1;
        @(posedge CLK); #1;
        cnt_clr = 1'b0;
        check("clr_wins", 32'(ovf_count), 32'd0);

        send_one("v_inc", 16'h7000, 1'b1, SAT ? 12'h1FF : 12'h000, 1'b1);
        @(posedge CLK); #1;
        check("inc_count", 32'(ovf_count), 32'd1);

        // Asynchronous reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h8000;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check("ar_full", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_ovf_count", 32'(ovf_count), 32'd0);
        check("ar_out_imm",   32'(out_imm),   32'd0);
        @(posedge CLK); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            stale = stale | out_valid;
        end
        check("ar_no_stale", 32'(stale), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
